// File: rtl/credit_based_multichannel_fifo.sv
// credit_based_multichannel_fifo: per-channel circular FIFOs drained round-robin
// under downstream credit flow control, with credit return pulses to upstream.
module credit_based_multichannel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CHANNELS = 2,
  parameter int CREDIT_COUNT = 4,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                write_valid,
  input  logic [CW-1:0]       write_channel,
  output logic [CHANNELS-1:0] write_credit,
  output logic [CHANNELS-1:0] full,
  output logic [CHANNELS-1:0] empty,
  output logic [WIDTH-1:0]    read_data,
  output logic                read_valid,
  output logic [CW-1:0]       read_channel,
  input  logic [CHANNELS-1:0] read_credit,
  output logic                overflow_error,
  output logic                credit_error
);
  localparam int PW = $clog2(DEPTH);
  localparam int KW = $clog2(CREDIT_COUNT + 1);
  logic [WIDTH-1:0] mem [CHANNELS][DEPTH];
  logic [PW:0] wptr [CHANNELS];
  logic [PW:0] rptr [CHANNELS];
  logic [KW-1:0] cnt [CHANNELS];
  logic [CW-1:0] last, grant, idx;
  logic grant_valid;
  logic [CHANNELS-1:0] elig, wr_hit, wr_en, deq, cr_bad;
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      empty[c] = wptr[c] == rptr[c];
      full[c] = (wptr[c] ^ rptr[c]) == {1'b1, {PW{1'b0}}};
      elig[c] = !empty[c] && cnt[c] != '0;
      wr_hit[c] = write_valid && write_channel == CW'(c);
      wr_en[c] = wr_hit[c] && !full[c];
    end
  end
  // Scan from farthest to nearest so the channel right after last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant = '0;
    idx = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = CW'((int'(last) + i) % CHANNELS);
      if (elig[idx]) begin
        grant_valid = 1'b1;
        grant = idx;
      end
    end
    deq = '0;
    cr_bad = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      deq[c] = grant_valid && grant == CW'(c);
      cr_bad[c] = read_credit[c] && !deq[c] && cnt[c] == KW'(CREDIT_COUNT);
    end
  end
  assign read_valid = grant_valid;
  assign read_channel = grant;
  assign read_data = mem[grant][rptr[grant][PW-1:0]];
  always_ff @(posedge clock)
    for (int c = 0; c < CHANNELS; c++)
      if (wr_en[c]) mem[c][wptr[c][PW-1:0]] <= write_data;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c] <= KW'(CREDIT_COUNT);
      end
      last <= CW'(CHANNELS - 1);
      write_credit <= '0;
      overflow_error <= 1'b0;
      credit_error <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_en[c]) wptr[c] <= wptr[c] + 1'b1;
        if (deq[c]) rptr[c] <= rptr[c] + 1'b1;
        if (read_credit[c] && !deq[c] && !cr_bad[c]) cnt[c] <= cnt[c] + 1'b1;
        else if (deq[c] && !read_credit[c]) cnt[c] <= cnt[c] - 1'b1;
      end
      if (grant_valid) last <= grant;
      write_credit <= deq;
      if (|(wr_hit & full)) overflow_error <= 1'b1;
      if (|cr_bad) credit_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_credit_based_multichannel_fifo.sv
// tb_credit_based_multichannel_fifo: directed vectors with hand-computed
// expectations for the default 2-channel, depth-4, 4-credit configuration.
module tb_credit_based_multichannel_fifo;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic write_valid = 1'b0;
  logic [0:0] write_channel = 1'b0;
  logic [1:0] write_credit, full, empty;
  logic [1:0] read_credit = 2'b00;
  logic [7:0] read_data;
  logic read_valid;
  logic [0:0] read_channel;
  logic overflow_error, credit_error;
  int checks = 0;
  int errors = 0;
  int wc0, wc1;
  int c_rc [9] = '{3, 3, 3, 0, 0, 0, 0, 0, 0};
  int c_v  [9] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
  int c_ch [9] = '{0, 0, 1, 0, 1, 0, 1, 0, 0};
  int c_d  [9] = '{0, 'h20, 'h30, 'h21, 'h31, 'h22, 'h32, 0, 0};
  always #5 clock = ~clock;
  credit_based_multichannel_fifo dut (
    .clock(clock), .resetn(resetn),
    .write_data(write_data), .write_valid(write_valid), .write_channel(write_channel),
    .write_credit(write_credit), .full(full), .empty(empty),
    .read_data(read_data), .read_valid(read_valid), .read_channel(read_channel),
    .read_credit(read_credit), .overflow_error(overflow_error), .credit_error(credit_error)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input int wv, input int ch, input int d, input int rc);
    @(negedge clock);
    write_valid = wv[0];
    write_channel = ch[0];
    write_data = 8'(d);
    read_credit = 2'(rc);
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0);
  endtask
  task automatic rd(input string tag, input int v, input int ch, input int d);
    check({tag, " valid"}, 32'(read_valid), v);
    if (v != 0) begin
      check({tag, " chan"}, 32'(read_channel), ch);
      check({tag, " data"}, 32'(read_data), d);
    end
  endtask
  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    write_valid = 1'b0;
    read_credit = 2'b00;
    #1;
    check("rst empty", 32'(empty), 3);
    check("rst full", 32'(full), 0);
    check("rst read_valid", 32'(read_valid), 0);
    check("rst write_credit", 32'(write_credit), 0);
    check("rst overflow", 32'(overflow_error), 0);
    check("rst credit_error", 32'(credit_error), 0);
    @(negedge clock);
    resetn = 1'b1;
  endtask
  initial begin
    do_reset();
    drive(1, 0, 'hA5, 0);
    rd("same cycle", 0, 0, 0);
    idle();
    rd("single N+1", 1, 0, 'hA5);
    check("single wc N+1", 32'(write_credit), 0);
    idle();
    rd("single N+2", 0, 0, 0);
    check("single wc N+2", 32'(write_credit), 1);
    check("single empty", 32'(empty), 3);
    idle();
    check("single wc N+3", 32'(write_credit), 0);
    do_reset();
    drive(0, 0, 0, 1);
    check("credit_error pre-edge", 32'(credit_error), 0);
    idle();
    check("credit_error set", 32'(credit_error), 1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 'h10 + i, 0);
      rd("stall", (i >= 1 && i <= 4) ? 1 : 0, 0, 'h10 + i - 1);
      check("stall wc", 32'(write_credit), (i >= 2 && i <= 5) ? 1 : 0);
    end
    idle();
    rd("stall blocked", 0, 0, 0);
    check("stall blocked wc", 32'(write_credit), 0);
    check("stall ch0 holds", 32'(empty), 2);
    check("stall no overflow", 32'(overflow_error), 0);
    drive(0, 0, 0, 1);
    rd("credit pending", 0, 0, 0);
    idle();
    rd("credit transfer", 1, 0, 'h14);
    idle();
    rd("credit spent", 0, 0, 0);
    check("credit wc", 32'(write_credit), 1);
    check("credit_error sticky", 32'(credit_error), 1);
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, i, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, i, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 'h20 + i, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 'h30 + i, 0);
    idle();
    rd("staged", 0, 0, 0);
    check("staged empty", 32'(empty), 0);
    wc0 = 0;
    wc1 = 0;
    for (int s = 0; s < 9; s++) begin
      drive(0, 0, 0, c_rc[s]);
      rd("rr", c_v[s], c_ch[s], c_d[s]);
      wc0 += int'(write_credit[0]);
      wc1 += int'(write_credit[1]);
    end
    check("rr wc0 pulses", wc0, 3);
    check("rr wc1 pulses", wc1, 3);
    check("rr empty", 32'(empty), 3);
    check("rr credit_error", 32'(credit_error), 0);
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, i, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 'h40 + i, 0);
    drive(1, 1, 'h44, 0);
    check("fill full", 32'(full), 2);
    check("fill overflow pre-edge", 32'(overflow_error), 0);
    idle();
    check("overflow set", 32'(overflow_error), 1);
    check("overflow full", 32'(full), 2);
    rd("overflow blocked", 0, 0, 0);
    drive(0, 1, 0, 2);
    rd("ovf s0", 0, 0, 0);
    drive(1, 1, 'h55, 2);
    rd("ovf s1", 1, 1, 'h40);
    check("ovf s1 full", 32'(full), 2);
    drive(1, 1, 'h66, 2);
    rd("ovf s2", 1, 1, 'h41);
    drive(0, 1, 0, 2);
    rd("ovf s3", 1, 1, 'h42);
    check("ovf s3 full", 32'(full), 0);
    idle();
    rd("ovf s4", 1, 1, 'h43);
    idle();
    rd("ovf s5", 0, 0, 0);
    check("ovf s5 empty", 32'(empty), 1);
    drive(0, 1, 0, 2);
    rd("ovf s6", 0, 0, 0);
    idle();
    rd("ovf s7", 1, 1, 'h66);
    idle();
    rd("ovf s8", 0, 0, 0);
    check("ovf s8 empty", 32'(empty), 3);
    check("overflow sticky", 32'(overflow_error), 1);
    drive(1, 1, 'h70, 0);
    drive(1, 1, 'h71, 0);
    drive(1, 0, 'h72, 0);
    drive(1, 0, 'h73, 0);
    rd("mid t3", 1, 0, 'h72);
    idle();
    rd("mid t4", 1, 0, 'h73);
    check("mid wc", 32'(write_credit), 1);
    check("mid empty", 32'(empty), 0);
    resetn = 1'b0;
    #1;
    check("mid rst empty", 32'(empty), 3);
    check("mid rst full", 32'(full), 0);
    check("mid rst read_valid", 32'(read_valid), 0);
    check("mid rst wc", 32'(write_credit), 0);
    check("mid rst overflow", 32'(overflow_error), 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post rst wc", 32'(write_credit), 0);
      rd("post rst", 0, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
